// File: rtl/cpu3_sum_display_if.sv
// Board-side signal bundle for the CPU3 sum display: slide switches in,
// multiplexed 7-segment drives out.
interface cpu3_sum_display_if;
  logic sw0, sw1, sw2, sw3, sw4, sw5, sw6, sw7, sw8, sw9, sw10, sw11, sw12, sw13;
  logic a, b, c, d, e, f, g, dp;
  logic d0, d1, d2, d3, d4, d5, d6, d7;

  modport master (
    output sw0, sw1, sw2, sw3, sw4, sw5, sw6, sw7, sw8, sw9, sw10, sw11, sw12, sw13,
    input  a, b, c, d, e, f, g, dp,
    input  d0, d1, d2, d3, d4, d5, d6, d7
  );

  modport slave (
    input  sw0, sw1, sw2, sw3, sw4, sw5, sw6, sw7, sw8, sw9, sw10, sw11, sw12, sw13,
    output a, b, c, d, e, f, g, dp,
    output d0, d1, d2, d3, d4, d5, d6, d7
  );
endinterface

// File: rtl/cpu3_sum_display.sv
// CPU3 board top: iterative S = 1+..+N, double-dabble to 8 BCD digits,
// shown on a scanned common-anode 8-digit display.
module cpu3_sum_display #(
  parameter int SCAN_DIV = 16
) (
  input  logic            clk,
  input  logic            sw14,
  cpu3_sum_display_if.slave io
);
  localparam int SW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, SUM, CONV, DONE} state_t;

  logic        rst_n;
  state_t      state, state_nx;
  logic        sw13_q, start;
  logic [12:0] n, sw_n;
  logic [13:0] i;
  logic [24:0] acc;
  logic [4:0]  cnt;
  logic [31:0] bcd, bcd_adj, disp;
  logic [SW+2:0] scan;
  logic [2:0]  idx;
  logic [3:0]  nib;
  logic [6:0]  seg;
  logic [7:0]  dig;

  assign rst_n = sw14;
  assign start = io.sw13 & ~sw13_q;
  assign sw_n  = {io.sw12, io.sw11, io.sw10, io.sw9, io.sw8, io.sw7, io.sw6,
                  io.sw5, io.sw4, io.sw3, io.sw2, io.sw1, io.sw0};

  // Per-digit add-3 correction applied before every double-dabble shift
  for (genvar k = 0; k < 8; k++) begin : g_dd
    assign bcd_adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? bcd[4*k +: 4] + 4'd3
                                                       : bcd[4*k +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = SUM;
      SUM:  if (i > {1'b0, n}) state_nx = CONV;
      CONV: if (cnt == 5'd24) state_nx = DONE;
      DONE: if (!io.sw13) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw13_q <= 1'b0;
      n      <= '0;
      i      <= '0;
      acc    <= '0;
      cnt    <= '0;
      bcd    <= '0;
      disp   <= '0;
    end else begin
      sw13_q <= io.sw13;
      case (state)
        IDLE: if (start) begin
          n   <= sw_n;
          acc <= '0;
          i   <= 14'd1;
        end
        SUM: if (i <= {1'b0, n}) begin
          acc <= acc + {11'd0, i};
          i   <= i + 14'd1;
        end else begin
          bcd <= '0;
          cnt <= '0;
        end
        CONV: begin
          // {bcd,acc} shifts left as one 57-bit register
          bcd <= {bcd_adj[30:0], acc[24]};
          acc <= {acc[23:0], 1'b0};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd24) disp <= {bcd_adj[30:0], acc[24]};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan <= '0;
    else        scan <= scan + 1'b1;
  end

  assign idx = scan[SW+2:SW];
  assign nib = disp[{idx, 2'b00} +: 4];
  assign dig = ~(8'b1 << idx);

  always_comb begin
    seg = 7'b111_1111;
    case (nib)
      4'd0: seg = 7'b100_0000;
      4'd1: seg = 7'b111_1001;
      4'd2: seg = 7'b010_0100;
      4'd3: seg = 7'b011_0000;
      4'd4: seg = 7'b001_1001;
      4'd5: seg = 7'b001_0010;
      4'd6: seg = 7'b000_0010;
      4'd7: seg = 7'b111_1000;
      4'd8: seg = 7'b000_0000;
      4'd9: seg = 7'b001_0000;
      default: seg = 7'b111_1111;
    endcase
  end

  assign {io.g, io.f, io.e, io.d, io.c, io.b, io.a} = seg;
  assign io.dp = 1'b1;
  assign {io.d7, io.d6, io.d5, io.d4, io.d3, io.d2, io.d1, io.d0} = dig;
endmodule

// File: tb/tb_cpu3_sum_display.sv
// Directed bench for cpu3_sum_display: reads results back off the scanned
// display pins and compares against hand-computed sums.
module tb_cpu3_sum_display;
  localparam int SCAN_DIV = 16;

  logic clk, sw14;
  int   tests, fails;

  cpu3_sum_display_if bus();
  cpu3_sum_display #(.SCAN_DIV(SCAN_DIV)) dut (.clk(clk), .sw14(sw14), .io(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] get_dig();
    return {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
  endfunction

  function automatic logic [6:0] get_seg();
    return {bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
  endfunction

  function automatic logic [3:0] seg2nib(input logic [6:0] s);
    case (s)
      7'b100_0000: return 4'd0;
      7'b111_1001: return 4'd1;
      7'b010_0100: return 4'd2;
      7'b011_0000: return 4'd3;
      7'b001_1001: return 4'd4;
      7'b001_0010: return 4'd5;
      7'b000_0010: return 4'd6;
      7'b111_1000: return 4'd7;
      7'b000_0000: return 4'd8;
      7'b001_0000: return 4'd9;
      default:     return 4'hF;
    endcase
  endfunction

  task automatic set_n(input logic [12:0] v);
    {bus.sw12, bus.sw11, bus.sw10, bus.sw9, bus.sw8, bus.sw7, bus.sw6,
     bus.sw5, bus.sw4, bus.sw3, bus.sw2, bus.sw1, bus.sw0} = v;
  endtask

  task automatic wait_cyc(input int nc);
    repeat (nc) @(negedge clk);
  endtask

  // Assemble the 8 digits from one full scan; unseen or undecodable digits read F
  task automatic read_display(output logic [31:0] val);
    logic [7:0] dg;
    val = 32'hFFFF_FFFF;
    repeat (8 * SCAN_DIV + 2) begin
      @(negedge clk);
      dg = get_dig();
      for (int k = 0; k < 8; k++)
        if (dg == ~(8'b1 << k)) val[4*k +: 4] = seg2nib(get_seg());
    end
  endtask

  task automatic do_reset();
    sw14 = 1'b0;
    #20;
    @(negedge clk);
    sw14 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.sw13 = 1'b0;
    set_n(13'd0);
    sw14 = 1'b0;
    #20;
    tests++;
    if (get_dig() !== 8'hFE) begin fails++; $display("FAIL reset_dig got %b want 11111110", get_dig()); end
    tests++;
    if (get_seg() !== 7'b100_0000) begin fails++; $display("FAIL reset_seg got %b want 1000000", get_seg()); end
    tests++;
    if (bus.dp !== 1'b1) begin fails++; $display("FAIL reset_dp got %b want 1", bus.dp); end
    @(negedge clk);
    sw14 = 1'b1;
    @(negedge clk);
    tests++;
    if (get_dig() !== 8'hFE) begin fails++; $display("FAIL post_reset_dig got %b want 11111110", get_dig()); end
  endtask

  // One run: optionally confirm the previous result is still shown early on
  task automatic test_sum(input string nm, input logic [12:0] nv,
                          input logic [31:0] expv, input logic [31:0] prev, input bit chk_prev);
    logic [31:0] v;
    set_n(nv);
    @(negedge clk);
    bus.sw13 = 1'b1;
    if (chk_prev) begin
      read_display(v);
      tests++;
      if (v !== prev) begin fails++; $display("FAIL %s_prev got %h want %h", nm, v, prev); end
    end
    wait_cyc(int'(nv) + 40);
    read_display(v);
    tests++;
    if (v !== expv) begin fails++; $display("FAIL %s got %h want %h", nm, v, expv); end
    tests++;
    if (bus.dp !== 1'b1) begin fails++; $display("FAIL %s_dp got %b want 1", nm, bus.dp); end
    bus.sw13 = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_mid_reset();
    logic [31:0] v;
    set_n(13'd1024);
    @(negedge clk);
    bus.sw13 = 1'b1;
    wait_cyc(500);
    sw14 = 1'b0;
    #1;
    tests++;
    if (get_dig() !== 8'hFE) begin fails++; $display("FAIL midrst_dig got %b want 11111110", get_dig()); end
    tests++;
    if (get_seg() !== 7'b100_0000) begin fails++; $display("FAIL midrst_seg got %b want 1000000", get_seg()); end
    bus.sw13 = 1'b0;
    #20;
    @(negedge clk);
    sw14 = 1'b1;
    wait_cyc(1100);
    read_display(v);
    tests++;
    if (v !== 32'h0) begin fails++; $display("FAIL midrst_hold got %h want 00000000", v); end
  endtask

  task automatic test_hold();
    logic [31:0] v;
    set_n(13'd100);
    @(negedge clk);
    bus.sw13 = 1'b1;
    wait_cyc(140);
    read_display(v);
    tests++;
    if (v !== 32'h0000_5050) begin fails++; $display("FAIL hold_first got %h want 00005050", v); end
    set_n(13'd5);
    wait_cyc(60);
    read_display(v);
    tests++;
    if (v !== 32'h0000_5050) begin fails++; $display("FAIL hold_norecompute got %h want 00005050", v); end
    bus.sw13 = 1'b0;
    wait_cyc(3);
    bus.sw13 = 1'b1;
    wait_cyc(50);
    read_display(v);
    tests++;
    if (v !== 32'h0000_0015) begin fails++; $display("FAIL hold_restart got %h want 00000015", v); end
    bus.sw13 = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_scan();
    logic [7:0] dg;
    int cur, prv, run, bad_hot, bad_step, bad_len, steps;
    prv = -1; run = 0; bad_hot = 0; bad_step = 0; bad_len = 0; steps = 0;
    repeat (20 * SCAN_DIV) begin
      @(negedge clk);
      dg = get_dig();
      cur = -1;
      for (int k = 0; k < 8; k++) if (dg == ~(8'b1 << k)) cur = k;
      if (cur < 0) bad_hot++;
      else if (prv < 0) prv = cur;
      else if (cur == prv) run++;
      else begin
        if (cur != (prv + 1) % 8) bad_step++;
        if (steps > 0 && run != SCAN_DIV - 1) bad_len++;
        steps++; run = 0; prv = cur;
      end
    end
    tests++;
    if (bad_hot !== 0) begin fails++; $display("FAIL scan_onehot bad cycles %0d want 0", bad_hot); end
    tests++;
    if (bad_step !== 0) begin fails++; $display("FAIL scan_order bad steps %0d want 0", bad_step); end
    tests++;
    if (bad_len !== 0) begin fails++; $display("FAIL scan_period bad dwells %0d want 0", bad_len); end
    tests++;
    if (steps < 16) begin fails++; $display("FAIL scan_advance steps %0d want >=16", steps); end
  endtask

  initial begin
    tests = 0; fails = 0;
    sw14 = 1'b0;
    test_reset();
    test_sum("n1024", 13'd1024, 32'h0052_4800, 32'h0, 1'b0);
    do_reset();
    test_sum("n137",  13'd137,  32'h0000_9453, 32'h0, 1'b0);
    test_sum("n0",    13'd0,    32'h0000_0000, 32'h0, 1'b0);
    test_sum("n8191", 13'd8191, 32'h3355_0336, 32'h0, 1'b1);
    test_mid_reset();
    test_hold();
    test_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
